uart_rx_cfg: RTL
================

UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, data bits per frame, legal 5..9.
REQ-002 SHALL have parameter OVERSAMPLE, default 16, os_tick pulses per bit period, even, legal 8..32.
REQ-003 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits checked per frame, legal 1..2.
REQ-005 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port uart_rx  input  1  asynchronous serial line, idle high.
REQ-008 SHALL have port os_tick  input  1  one-clk strobe at OVERSAMPLE x baud rate.
REQ-009 SHALL have port data  output  DATA_BITS  last received word, LSB first on line.
REQ-010 SHALL have port valid_data  output  1  one-clk pulse, data/error flags updated.
REQ-011 SHALL have port parity_err  output  1  parity mismatch in last frame.
REQ-012 SHALL have port frame_err  output  1  any stop bit sampled low in last frame.
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL pass uart_rx through a 2-flop synchroniser reset to 1; all sampling uses the synchronised value.
REQ-015 SHALL implement states IDLE, START, DATA, PARITY, STOP; the tick counter and the bit counter advance only on os_tick.
REQ-016 IDLE: on os_tick with rx=0, go to START with tick counter cleared; otherwise stay.
REQ-017 START: at tick OVERSAMPLE/2-1, if rx=1 return to IDLE with no flags and no valid_data (false start); else clear counters and go to DATA.
REQ-018 DATA: sample rx every OVERSAMPLE ticks (mid-bit); shift in LSB first; after DATA_BITS samples go to PARITY if PARITY!=0, else to STOP.
REQ-019 PARITY: sample one bit mid-bit; error if XOR(data bits, parity bit) is 0 for odd or 1 for even.
REQ-020 STOP: sample STOP_BITS bits mid-bit; frame_err is set if any sample is 0.
REQ-021 After the mid-bit sample of the last stop bit, the FSM SHALL return to IDLE immediately, so a start bit following directly is detected.
REQ-022 Latency: data, parity_err, frame_err and valid_data SHALL update on the clk edge after the os_tick that samples the last stop bit.
REQ-023 valid_data SHALL pulse even when errors occur; flags qualify the pulse and hold until the next frame completes.
REQ-024 Break (all bits 0, stop 0) SHALL give valid_data with data=0 and frame_err=1; the FSM SHALL not re-arm until rx has been seen high for one os_tick in IDLE.
REQ-025 os_tick high for consecutive clks SHALL count each clk as one tick; without os_tick the FSM SHALL hold state.
REQ-026 parity_err SHALL stay 0 when PARITY=0.

Reset
REQ-027 rst SHALL force IDLE, clear all counters and the shift register, set data=0, valid_data=0, parity_err=0, frame_err=0, busy=0, synchroniser=1.
REQ-028 rst mid-frame SHALL abandon the frame with no valid_data pulse, then resume on the next start bit after release.

Structure
REQ-029 The shared package uart_pkg SHALL hold the state encoding and the parity mode constants (PAR_NONE, PAR_ODD, PAR_EVEN).
REQ-030 The synchroniser SHALL be the single sub-module uart_rx_sync; the FSM, counters and shift register stay in uart_rx_cfg.

Verification (OVERSAMPLE=16, os_tick every 4 clks)
REQ-031 Defaults, send 0xA5 with 1 stop bit -> one valid_data pulse, data=0xA5, parity_err=0, frame_err=0.
REQ-032 PARITY=2, send 0x07 with parity bit 0 -> data=0x07, parity_err=1; repeat with parity bit 1 -> parity_err=0.
REQ-033 Low glitch of 5 ticks on an idle line -> no valid_data, busy returns to 0 by tick 8.
REQ-034 Send 0x3C with stop bit forced 0, then 0x55 back-to-back -> first gives frame_err=1, second gives data=0x55 with frame_err=0.
REQ-035 Assert rst during data bit 4 of 0xFF, then send 0x12 -> no pulse for 0xFF, data=0x12 valid.
REQ-036 DATA_BITS=7, STOP_BITS=2, send 0x41 with second stop bit 0 -> data=0x41, frame_err=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver: FSM encoding and parity modes.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the idle level.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;

  // Shift the line through two flops; reset to 1 so no false start appears on release.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], d};
    end
  end

  assign q = sync_q[1];

endmodule

// File: rtl/uart_rx_cfg.sv
// Oversampling UART receiver with configurable data width, parity and stop bits.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 uart_rx,
  input  logic                 os_tick,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid_data,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = 4;
  localparam logic [TW-1:0] T_HALF      = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_LAST      = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] B_STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic          HAS_PAR     = (PARITY != PAR_NONE);

  state_t                 state, next_state;
  logic                   rx_s;
  logic [TW-1:0]          tick_cnt;
  logic [BW-1:0]          bit_cnt;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   par_err_acc, frm_err_acc, armed;
  logic                   at_half, at_last, par_x, par_err_c;
  logic                   cnt_clr, cnt_inc, bit_clr, bit_inc;
  logic                   shift_en, par_en, stop_en, done;

  uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (uart_rx),
    .q   (rx_s)
  );

  assign at_half = (tick_cnt == T_HALF);
  assign at_last = (tick_cnt == T_LAST);

  // Parity check against the received bit: odd wants XOR=1, even wants XOR=0.
  always_comb begin
    par_x     = (^shift_q) ^ rx_s;
    par_err_c = 1'b0;
    if (PARITY == PAR_ODD)  par_err_c = ~par_x;
    if (PARITY == PAR_EVEN) par_err_c = par_x;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next-state logic; every transition is gated by os_tick so the FSM holds without it.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (os_tick && !rx_s && armed) next_state = ST_START;
      ST_START:  if (os_tick && at_half) next_state = rx_s ? ST_IDLE : ST_DATA;
      ST_DATA:   if (os_tick && at_last && (bit_cnt == B_DATA_LAST))
                   next_state = HAS_PAR ? ST_PARITY : ST_STOP;
      ST_PARITY: if (os_tick && at_last) next_state = ST_STOP;
      ST_STOP:   if (os_tick && at_last && (bit_cnt == B_STOP_LAST)) next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Datapath control strobes decoded from state and the tick counter.
  always_comb begin
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    bit_clr  = 1'b0;
    bit_inc  = 1'b0;
    shift_en = 1'b0;
    par_en   = 1'b0;
    stop_en  = 1'b0;
    done     = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        bit_clr = 1'b1;
      end
      ST_START: if (os_tick) begin
        if (at_half) begin
          cnt_clr = 1'b1;
          bit_clr = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_DATA: if (os_tick) begin
        if (at_last) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_cnt == B_DATA_LAST) bit_clr = 1'b1;
          else                        bit_inc = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_PARITY: if (os_tick) begin
        if (at_last) begin
          cnt_clr = 1'b1;
          par_en  = 1'b1;
          bit_clr = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_STOP: if (os_tick) begin
        if (at_last) begin
          cnt_clr = 1'b1;
          stop_en = 1'b1;
          bit_inc = 1'b1;
          done    = (bit_cnt == B_STOP_LAST);
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Counters, shift register, error accumulators and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shift_q     <= '0;
      par_err_acc <= 1'b0;
      frm_err_acc <= 1'b0;
      armed       <= 1'b1;
      data        <= '0;
      valid_data  <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      valid_data <= done;
      busy       <= (next_state != ST_IDLE);

      if (cnt_clr)      tick_cnt <= '0;
      else if (cnt_inc) tick_cnt <= tick_cnt + TW'(1);

      if (bit_clr)      bit_cnt <= '0;
      else if (bit_inc) bit_cnt <= bit_cnt + BW'(1);

      if (shift_en) shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};

      if (state == ST_IDLE) begin
        par_err_acc <= 1'b0;
        frm_err_acc <= 1'b0;
      end
      if (par_en)            par_err_acc <= par_err_c;
      if (stop_en && !rx_s)  frm_err_acc <= 1'b1;

      if (done) begin
        data       <= shift_q;
        parity_err <= par_err_acc;
        frame_err  <= frm_err_acc | ~rx_s;
        // A break (all-zero word, low stop) disarms start detection until the line idles.
        if ((shift_q == '0) && (frm_err_acc | ~rx_s)) armed <= 1'b0;
      end
      if ((state == ST_IDLE) && os_tick && rx_s) armed <= 1'b1;
    end
  end

endmodule
